// File: rtl/fcmp_pipe_if.sv
// Issue/writeback handshake bundle for the FPU compare pipe.
// The unit side uses the slave modport; the issuing side uses master.
interface fcmp_pipe_if #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int TAG_W = 5
);
    localparam int W = 1 + EXP_W + MAN_W;

    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_op;
    logic [W-1:0]     in_a;
    logic [W-1:0]     in_b;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic             out_res;
    logic             out_nv;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, in_op, in_a, in_b, in_tag, out_ready,
        input  in_ready, out_valid, out_res, out_nv, out_tag
    );

    modport slave (
        input  in_valid, in_op, in_a, in_b, in_tag, out_ready,
        output in_ready, out_valid, out_res, out_nv, out_tag
    );
endinterface

// File: rtl/fcmp_pipe.sv
// Two-stage IEEE-754 comparator (EQ/LT/LE) with NaN classification,
// invalid-operation flag and a sticky invalid flag; valid/ready on both sides.
module fcmp_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int TAG_W = 5
) (
    input  logic       clk,
    input  logic       rstn,
    fcmp_pipe_if.slave bus,
    input  logic       clr_flags,
    output logic       nv_sticky
);
    localparam int W = 1 + EXP_W + MAN_W;
    localparam int M = W - 1;

    typedef struct packed {
        logic nan;
        logic snan;
        logic zero;
        logic sgn;
    } cls_t;

    typedef struct packed {
        logic [1:0]       op;
        logic [TAG_W-1:0] tag;
        cls_t             a;
        cls_t             b;
        logic             mag_lt;
        logic             mag_eq;
    } s1_t;

    function automatic cls_t classify(input logic [W-1:0] x);
        cls_t c;
        c.sgn  = x[W-1];
        c.nan  = (&x[M-1:MAN_W]) && (|x[MAN_W-1:0]);
        c.snan = c.nan && !x[MAN_W-1];
        c.zero = ~|x[M-1:0];
        return c;
    endfunction

    logic [2:1]       r_vld_pipe;
    s1_t              r_s1;
    logic             r_res;
    logic             r_nv;
    logic [TAG_W-1:0] r_tag;
    logic             r_sticky;

    logic w_s1_adv;
    logic w_s2_adv;
    logic w_acc;
    s1_t  w_s1_d;
    logic w_any_nan;
    logic w_any_snan;
    logic w_both_zero;
    logic w_eq;
    logic w_lt;
    logic w_res;
    logic w_nv;

    assign w_s2_adv = ~r_vld_pipe[2] | bus.out_ready;
    assign w_s1_adv = ~r_vld_pipe[1] | w_s2_adv;
    assign w_acc    = bus.in_valid & w_s1_adv;

    assign bus.in_ready  = w_s1_adv;
    assign bus.out_valid = r_vld_pipe[2];
    assign bus.out_res   = r_res;
    assign bus.out_nv    = r_nv;
    assign bus.out_tag   = r_tag;
    assign nv_sticky     = r_sticky;

    // Magnitude compare on {exp,man} as an unsigned integer; sign handled in S2.
    always_comb begin
        w_s1_d        = '0;
        w_s1_d.op     = bus.in_op;
        w_s1_d.tag    = bus.in_tag;
        w_s1_d.a      = classify(bus.in_a);
        w_s1_d.b      = classify(bus.in_b);
        w_s1_d.mag_lt = bus.in_a[M-1:0] < bus.in_b[M-1:0];
        w_s1_d.mag_eq = bus.in_a[M-1:0] == bus.in_b[M-1:0];
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_vld_pipe <= '0;
            r_s1       <= '0;
        end else begin
            if (w_s1_adv) r_vld_pipe[1] <= bus.in_valid;
            if (w_s2_adv) r_vld_pipe[2] <= r_vld_pipe[1];
            if (w_acc)    r_s1          <= w_s1_d;
        end
    end

    always_comb begin
        w_any_nan   = r_s1.a.nan  | r_s1.b.nan;
        w_any_snan  = r_s1.a.snan | r_s1.b.snan;
        w_both_zero = r_s1.a.zero & r_s1.b.zero;
        w_eq        = ((r_s1.a.sgn == r_s1.b.sgn) && r_s1.mag_eq) || w_both_zero;
        w_lt        = 1'b0;
        if (r_s1.a.sgn != r_s1.b.sgn)
            w_lt = r_s1.a.sgn && !w_both_zero;
        else if (!r_s1.a.sgn)
            w_lt = r_s1.mag_lt;
        else
            w_lt = !r_s1.mag_lt && !r_s1.mag_eq;

        w_res = 1'b0;
        w_nv  = 1'b1;
        case (r_s1.op)
            2'd0: begin w_res = w_eq & ~w_any_nan;          w_nv = w_any_snan; end
            2'd1: begin w_res = w_lt & ~w_any_nan;          w_nv = w_any_nan;  end
            2'd2: begin w_res = (w_lt | w_eq) & ~w_any_nan; w_nv = w_any_nan;  end
            default: begin w_res = 1'b0;                    w_nv = 1'b1;       end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_res <= 1'b0;
            r_nv  <= 1'b0;
            r_tag <= '0;
        end else if (w_s2_adv && r_vld_pipe[1]) begin
            r_res <= w_res;
            r_nv  <= w_nv;
            r_tag <= r_s1.tag;
        end
    end

    // A flagged handshake in the same cycle as a clear keeps the flag set.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            r_sticky <= 1'b0;
        else if (r_vld_pipe[2] && bus.out_ready && r_nv)
            r_sticky <= 1'b1;
        else if (clr_flags)
            r_sticky <= 1'b0;
    end
endmodule
